// File: rtl/sprite_oam_dma.sv
// Sprite OAM DMA: copies COUNT words from source memory into sprite RAM at
// one word per cycle, triggered by a START write or (in AUTO mode) frame end.
module sprite_oam_dma #(
  parameter int ADDR_WIDTH = 6,
  parameter int SRC_AW     = 16
) (
  input  logic                  clk_50MHz,
  input  logic                  rstn,
  input  logic                  vga_intr,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic [31:0]           cfg_rdata,
  output logic                  src_rd,
  output logic [SRC_AW-1:0]     src_addr,
  input  logic [31:0]           src_rdata,
  output logic                  spr_we,
  output logic [ADDR_WIDTH-1:0] spr_addr,
  output logic [31:0]           spr_wdata,
  output logic                  busy,
  output logic                  done_irq
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                state, state_nxt;
  logic                  ctrl_auto;
  logic [SRC_AW-1:0]     src_base;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] rd_idx, last_idx;
  logic                  st_done, st_overrun;
  logic [31:0]           wdata_hold;
  logic                  ctrl_wr, status_wr, trigger, rd_last;
  logic                  unused_wdata;

  assign ctrl_wr   = cfg_we && (cfg_addr == 2'd0);
  assign status_wr = cfg_we && (cfg_addr == 2'd3);
  assign trigger   = (ctrl_wr && cfg_wdata[1]) || (ctrl_auto && vga_intr);
  assign rd_last   = (rd_idx == last_idx);

  assign busy      = (state == S_RUN) || (state == S_FLUSH);
  assign done_irq  = (state == S_DONE);
  // Read data arrives in the same cycle as its write strobe, so it is passed
  // through combinationally and only captured to hold the bus afterwards.
  assign spr_wdata = spr_we ? src_rdata : wdata_hold;
  assign unused_wdata = ^cfg_wdata;

  always_ff @(posedge clk_50MHz) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger) state_nxt = S_RUN;
      S_RUN:   if (rd_last) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rstn) begin
      ctrl_auto  <= 1'b0;
      src_base   <= '0;
      count      <= '0;
      st_done    <= 1'b0;
      st_overrun <= 1'b0;
      src_rd     <= 1'b0;
      src_addr   <= '0;
      rd_idx     <= '0;
      last_idx   <= '0;
      spr_we     <= 1'b0;
      spr_addr   <= '0;
      wdata_hold <= '0;
    end else begin
      if (ctrl_wr)                       ctrl_auto <= cfg_wdata[0];
      if (cfg_we && cfg_addr == 2'd1)    src_base  <= cfg_wdata[SRC_AW-1:0];
      if (cfg_we && cfg_addr == 2'd2)    count     <= cfg_wdata[ADDR_WIDTH-1:0];

      // Setting wins over a coincident write-1-to-clear.
      st_done    <= (state == S_DONE) || (st_done && !(status_wr && cfg_wdata[1]));
      st_overrun <= (trigger && state != S_IDLE) ||
                    (st_overrun && !(status_wr && cfg_wdata[2]));

      if (state == S_IDLE && trigger) begin
        src_rd   <= 1'b1;
        src_addr <= src_base;
        rd_idx   <= '0;
        last_idx <= count - ADDR_WIDTH'(1);
      end else if (state == S_RUN && !rd_last) begin
        src_rd   <= 1'b1;
        src_addr <= src_addr + SRC_AW'(1);
        rd_idx   <= rd_idx + ADDR_WIDTH'(1);
      end else begin
        src_rd   <= 1'b0;
      end

      spr_we <= src_rd;
      if (src_rd) spr_addr   <= rd_idx;
      if (spr_we) wdata_hold <= src_rdata;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[0] = ctrl_auto;
      2'd1: cfg_rdata = 32'(src_base);
      2'd2: cfg_rdata = 32'(count);
      2'd3: cfg_rdata[2:0] = {st_overrun, st_done, busy};
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sprite_oam_dma.sv
// Directed bench for sprite_oam_dma with a one-cycle-latency source memory model.
module tb_sprite_oam_dma;

  logic        clk_50MHz = 1'b0;
  logic        rstn = 1'b0;
  logic        vga_intr = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic        src_rd;
  logic [15:0] src_addr;
  logic [31:0] src_rdata = 32'hDEAD_BEEF;
  logic        spr_we;
  logic [5:0]  spr_addr;
  logic [31:0] spr_wdata;
  logic        busy;
  logic        done_irq;

  int tests = 0;
  int fails = 0;

  sprite_oam_dma #(.ADDR_WIDTH(6), .SRC_AW(16)) dut (
    .clk_50MHz(clk_50MHz), .rstn(rstn), .vga_intr(vga_intr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata),
    .spr_we(spr_we), .spr_addr(spr_addr), .spr_wdata(spr_wdata),
    .busy(busy), .done_irq(done_irq)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  always @(posedge clk_50MHz) src_rdata <= src_rd ? mem_word(src_addr) : 32'hDEAD_BEEF;

  int          wr_n = 0, rd_n = 0, done_n = 0;
  logic [5:0]  wr_addr_log [1024];
  logic [31:0] wr_data_log [1024];
  logic [15:0] rd_addr_log [1024];

  always @(negedge clk_50MHz) begin
    if (spr_we) begin
      wr_addr_log[wr_n] = spr_addr;
      wr_data_log[wr_n] = spr_wdata;
      wr_n = wr_n + 1;
    end
    if (src_rd) begin
      rd_addr_log[rd_n] = src_addr;
      rd_n = rd_n + 1;
    end
    if (done_irq) done_n = done_n + 1;
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_50MHz);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk_50MHz);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_50MHz);
      if (done_irq) found = 1'b1;
    end
  endtask

  task automatic pulse_vga();
    @(negedge clk_50MHz); vga_intr = 1'b1;
    @(negedge clk_50MHz); vga_intr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rstn = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    tests++;
    if ({src_rd, spr_we, busy, done_irq} !== 4'b0) begin
      fails++; $display("FAIL reset_strobes got=%b exp=0000", {src_rd, spr_we, busy, done_irq});
    end
    tests++;
    if (src_addr !== 16'h0 || spr_addr !== 6'h0 || spr_wdata !== 32'h0) begin
      fails++; $display("FAIL reset_buses got=%h/%h/%h exp=0/0/0", src_addr, spr_addr, spr_wdata);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), r);
      tests++;
      if (r !== 32'h0) begin fails++; $display("FAIL reset_reg%0d got=%h exp=0", a, r); end
    end
    rstn = 1'b1;
    @(negedge clk_50MHz);
  endtask

  task automatic test_basic();
    logic [31:0] r;
    int w;
    cfg_write(2'd1, 32'h0100);
    cfg_write(2'd2, 32'd4);
    @(negedge clk_50MHz);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h2;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_50MHz);
      cfg_we = 1'b0;
      w = (k < 2) ? 0 : ((k - 2 > 3) ? 3 : k - 2);
      tests++;
      if (src_rd !== (k >= 1 && k <= 4)) begin
        fails++; $display("FAIL basic_src_rd k=%0d got=%b", k, src_rd);
      end
      tests++;
      if (src_addr !== 16'h0100 + 16'((k > 4 ? 4 : k) - 1)) begin
        fails++; $display("FAIL basic_src_addr k=%0d got=%h", k, src_addr);
      end
      tests++;
      if (spr_we !== (k >= 2 && k <= 5)) begin
        fails++; $display("FAIL basic_spr_we k=%0d got=%b", k, spr_we);
      end
      if (k >= 2 && k <= 5) begin
        tests++;
        if (spr_addr !== 6'(w) || spr_wdata !== mem_word(16'h0100 + 16'(w))) begin
          fails++; $display("FAIL basic_write k=%0d got=%h:%h exp=%h:%h", k, spr_addr, spr_wdata,
                            6'(w), mem_word(16'h0100 + 16'(w)));
        end
      end
      tests++;
      if (busy !== (k >= 1 && k <= 5) || done_irq !== (k == 6)) begin
        fails++; $display("FAIL basic_busy_done k=%0d got=%b%b", k, busy, done_irq);
      end
    end
    cfg_read(2'd3, r);
    tests++;
    if (r !== 32'h2) begin fails++; $display("FAIL basic_status got=%h exp=2", r); end
    cfg_write(2'd3, 32'h2);
    cfg_read(2'd3, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL basic_status_clr got=%h exp=0", r); end
  endtask

  task automatic test_auto64();
    logic [31:0] r;
    bit found;
    int w0, d0;
    cfg_write(2'd1, 32'h0300);
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd0, 32'h1);
    w0 = wr_n; d0 = done_n;
    pulse_vga();
    wait_done(found);
    tests++;
    if (!found) begin fails++; $display("FAIL auto64_timeout got=no done exp=done"); end
    repeat (3) @(negedge clk_50MHz);
    tests++;
    if (wr_n - w0 != 64 || done_n - d0 != 1) begin
      fails++; $display("FAIL auto64_counts got=%0d/%0d exp=64/1", wr_n - w0, done_n - d0);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (wr_addr_log[w0 + i] !== 6'(i) || wr_data_log[w0 + i] !== mem_word(16'h0300 + 16'(i))) begin
        fails++; $display("FAIL auto64_word%0d got=%h:%h exp=%h:%h", i, wr_addr_log[w0 + i],
                          wr_data_log[w0 + i], 6'(i), mem_word(16'h0300 + 16'(i)));
      end
    end
    cfg_read(2'd3, r);
    tests++;
    if (r !== 32'h2) begin fails++; $display("FAIL auto64_status got=%h exp=2", r); end
    cfg_write(2'd3, 32'h6);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [4];
    bit found;
    int r0, w0;
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    cfg_write(2'd0, 32'h0);
    cfg_write(2'd1, 32'hFFFE);
    cfg_write(2'd2, 32'd4);
    r0 = rd_n; w0 = wr_n;
    cfg_write(2'd0, 32'h2);
    wait_done(found);
    tests++;
    if (!found) begin fails++; $display("FAIL wrap_timeout got=no done exp=done"); end
    repeat (3) @(negedge clk_50MHz);
    tests++;
    if (rd_n - r0 != 4) begin fails++; $display("FAIL wrap_reads got=%0d exp=4", rd_n - r0); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_addr_log[r0 + i] !== exp_a[i] || wr_data_log[w0 + i] !== mem_word(exp_a[i])) begin
        fails++; $display("FAIL wrap_addr%0d got=%h:%h exp=%h:%h", i, rd_addr_log[r0 + i],
                          wr_data_log[w0 + i], exp_a[i], mem_word(exp_a[i]));
      end
    end
    cfg_write(2'd3, 32'h6);
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    bit found;
    int w0, d0, r0;
    cfg_write(2'd1, 32'h0400);
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd0, 32'h1);
    w0 = wr_n; d0 = done_n; r0 = rd_n;
    pulse_vga();
    repeat (2) @(negedge clk_50MHz);
    vga_intr = 1'b1;
    @(negedge clk_50MHz);
    vga_intr = 1'b0;
    wait_done(found);
    tests++;
    if (!found) begin fails++; $display("FAIL overrun_timeout got=no done exp=done"); end
    repeat (3) @(negedge clk_50MHz);
    tests++;
    if (wr_n - w0 != 64 || rd_n - r0 != 64 || done_n - d0 != 1) begin
      fails++; $display("FAIL overrun_counts got=%0d/%0d/%0d exp=64/64/1", wr_n - w0, rd_n - r0, done_n - d0);
    end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (wr_addr_log[w0 + i] !== 6'(i) || rd_addr_log[r0 + i] !== 16'h0400 + 16'(i)) begin
        fails++; $display("FAIL overrun_seq%0d got=%h/%h exp=%h/%h", i, wr_addr_log[w0 + i],
                          rd_addr_log[r0 + i], 6'(i), 16'h0400 + 16'(i));
      end
    end
    cfg_read(2'd3, r);
    tests++;
    if (r !== 32'h6) begin fails++; $display("FAIL overrun_status got=%h exp=6", r); end
    cfg_write(2'd3, 32'h6);
    cfg_read(2'd3, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL overrun_clear got=%h exp=0", r); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] r;
    bit found;
    int w0, d0;
    cfg_write(2'd2, 32'd4);
    w0 = wr_n; d0 = done_n;
    @(negedge clk_50MHz);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h3; vga_intr = 1'b1;
    @(negedge clk_50MHz);
    cfg_we = 1'b0; vga_intr = 1'b0;
    wait_done(found);
    tests++;
    if (!found) begin fails++; $display("FAIL same_timeout got=no done exp=done"); end
    repeat (3) @(negedge clk_50MHz);
    tests++;
    if (wr_n - w0 != 4 || done_n - d0 != 1) begin
      fails++; $display("FAIL same_counts got=%0d/%0d exp=4/1", wr_n - w0, done_n - d0);
    end
    cfg_read(2'd3, r);
    tests++;
    if (r !== 32'h2) begin fails++; $display("FAIL same_status got=%h exp=2", r); end
    cfg_write(2'd3, 32'h6);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bit hit;
    int w0, d0;
    cfg_write(2'd1, 32'h0500);
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd0, 32'h1);
    w0 = wr_n; d0 = done_n;
    pulse_vga();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk_50MHz);
      if (spr_we && spr_addr == 6'd10) hit = 1'b1;
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL rstmid_word10 got=not seen exp=seen"); end
    rstn = 1'b0;
    @(negedge clk_50MHz);
    tests++;
    if (spr_we !== 1'b0 || busy !== 1'b0 || src_rd !== 1'b0) begin
      fails++; $display("FAIL rstmid_abort got=%b%b%b exp=000", spr_we, busy, src_rd);
    end
    rstn = 1'b1;
    repeat (80) @(negedge clk_50MHz);
    tests++;
    if (wr_n - w0 != 11 || done_n - d0 != 0) begin
      fails++; $display("FAIL rstmid_counts got=%0d/%0d exp=11/0", wr_n - w0, done_n - d0);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), r);
      tests++;
      if (r !== 32'h0) begin fails++; $display("FAIL rstmid_reg%0d got=%h exp=0", a, r); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto64();
    test_wrap();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_oam_dma.md
SPRITE_OAM_DMA -- requirements
Module: sprite_oam_dma

Interface
REQ-001 Parameter: ADDR_WIDTH, default 6, sprite RAM entry address width (64 entries).
REQ-002 Parameter: SRC_AW, default 16, source memory word-address width.
REQ-003 Port: clk_50MHz  input  1  single clock for all logic.
REQ-004 Port: rstn  input  1  synchronous, active-low reset, sampled on the rising edge of clk_50MHz.
REQ-005 Port: vga_intr  input  1  one-cycle frame-end pulse from the PPU, synchronous to clk_50MHz.
REQ-006 Port: cfg_we  input  1  register write strobe.
REQ-007 Port: cfg_addr  input  2  register select: 0 CTRL, 1 SRC_BASE, 2 COUNT, 3 STATUS.
REQ-008 Port: cfg_wdata  input  32  register write data.
REQ-009 Port: cfg_rdata  output  32  register read data.
REQ-010 Port: src_rd  output  1  source memory read strobe.
REQ-011 Port: src_addr  output  SRC_AW  source memory word address.
REQ-012 Port: src_rdata  input  32  source read data, valid exactly 1 cycle after src_rd.
REQ-013 Port: spr_we  output  1  sprite RAM write strobe.
REQ-014 Port: spr_addr  output  ADDR_WIDTH  sprite RAM entry index.
REQ-015 Port: spr_wdata  output  32  sprite entry data.
REQ-016 Port: busy  output  1  transfer in progress.
REQ-017 Port: done_irq  output  1  one-cycle pulse at transfer completion.

Function
REQ-018 Registers: CTRL[0] AUTO (vga_intr triggers a transfer), CTRL[1] START (write-1 trigger, self-clearing, reads 0); SRC_BASE[SRC_AW-1:0]; COUNT[5:0], where 0 means 64; STATUS[0] busy (RO), STATUS[1] DONE (sticky, write-1-to-clear), STATUS[2] OVERRUN (sticky, write-1-to-clear).
REQ-019 cfg_rdata: combinational function of cfg_addr; unused bits read 0.
REQ-020 Trigger: (cfg_we & cfg_addr==0 & cfg_wdata[1]) or (AUTO & vga_intr); both in the same cycle count as one trigger.
REQ-021 FSM states:
  - IDLE -> RUN on a trigger.
  - RUN -> FLUSH after the last read is issued.
  - FLUSH -> DONE after the last write.
  - DONE -> IDLE unconditionally.
REQ-022 At the trigger edge, SRC_BASE and COUNT are snapshotted; register writes during a transfer update the registers but affect only the next transfer.
REQ-023 Timing, with the trigger in cycle t and N words:
  - src_rd is high in cycles t+1 .. t+N, with src_addr = base+i.
  - spr_we is high in cycles t+2 .. t+N+1, with spr_addr = i and spr_wdata = src_rdata.
  - done_irq is high in cycle t+N+2.
REQ-024 Throughput is 1 word/cycle with no bubbles; busy is high from t+1 through t+N+1 and low in the done_irq cycle.
REQ-025 src_addr is computed modulo 2^SRC_AW and wraps silently; spr_addr is always 0..N-1.
REQ-026 A trigger while busy or in DONE is ignored and sets OVERRUN; the current transfer is unaffected.
REQ-027 DONE is set in the done_irq cycle; if a write-1-to-clear of DONE coincides with setting it, the set wins.
REQ-028 When src_rd/spr_we are low, src_addr/spr_addr/spr_wdata hold their last values.

Reset
REQ-029 While rstn=0 at a clock edge, all registers clear: CTRL=0, SRC_BASE=0, COUNT=0, STATUS=0, FSM=IDLE.
REQ-030 Reset values of outputs: src_rd, spr_we, busy and done_irq are 0; src_addr, spr_addr, spr_wdata and cfg_rdata are 0 (cfg_rdata at address 0).
REQ-031 Reset mid-transfer aborts it at that edge: no further writes, no done_irq, DONE not set.

Verification
REQ-032 SRC_BASE=0x0100, COUNT=4, write CTRL=0x2 at cycle t -> src_rd at t+1..t+4 (addr 0x0100..0x0103); spr_we at t+2..t+5 (idx 0..3, data matching the source); done_irq at t+6; STATUS=0x2.
REQ-033 COUNT=0, AUTO=1, pulse vga_intr -> 64 writes, spr_addr 0..63, then a single done_irq.
REQ-034 SRC_BASE=0xFFFE, COUNT=4 -> src_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-035 A second vga_intr 3 cycles into a 64-word transfer -> no restart, still exactly 64 writes, STATUS=0x6; writing 0x6 to STATUS -> reads 0.
REQ-036 Same-cycle START write and vga_intr with AUTO=1 -> one transfer, OVERRUN stays 0.
REQ-037 rstn=0 for 1 cycle during word 10 of a transfer -> spr_we low from the next cycle, no done_irq, all registers read 0.
